// File: rtl/lmg_drain_sequencer.sv
// Drains legal moves from the LMG FIFO into the move-list RAM, then writes a count header.
// Optional zero sentinel after the last move: define LMG_DRAIN_TERMINATOR_EN.
module lmg_drain_sequencer #(
    parameter int ADDR_WIDTH = 15,
    parameter int BASE_ADDR  = 17,
    parameter int HDR_ADDR   = 16,
    parameter int MAX_MOVES  = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            move_count,
    output logic                  overflow,
    output logic                  lmg_reset,
    input  logic                  lmg_done,
    input  logic                  lmg_fifo_empty,
    output logic                  lmg_rden,
    input  logic [151:0]          lmg_fifo_out,
    output logic                  ram_req,
    input  logic                  ram_gnt,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_wraddr,
    output logic [31:0]           ram_wdata
);

    typedef enum logic [3:0] {
        IDLE,
        LRST,
        WAIT,
        POP,
        LAT,
        SCAN,
        HDR,
`ifdef LMG_DRAIN_TERMINATOR_EN
        TERM,
`endif
        DONE
    } seqState;

    localparam logic [ADDR_WIDTH-1:0] baseAddr = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] hdrAddr  = ADDR_WIDTH'(HDR_ADDR);
    localparam logic [7:0]            maxMoves = 8'(MAX_MOVES);

    seqState        state;
    seqState        stateNext;
    logic           startPrev;
    logic [151:0]   wordReg;
    logic [2:0]     slotIdx;
    logic           anyValid;
    logic [7:0]     moveCount;
    logic           overflowReg;

    logic           launch;
    logic           capture;
    logic           step;
    logic           incCount;
    logic           setOverflow;

    logic [18:0]    slots [8];
    logic [18:0]    curSlot;
    logic           startEdge;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : gSlot
            assign slots[gi] = wordReg[19*gi +: 19];
        end
    endgenerate

    assign curSlot    = slots[slotIdx];
    assign startEdge  = start & ~startPrev;
    assign busy       = (state != IDLE) && (state != DONE);
    assign done       = (state == DONE);
    assign ram_wren   = ram_req & ram_gnt;
    assign move_count = moveCount;
    assign overflow   = overflowReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            startPrev   <= 1'b0;
            wordReg     <= '0;
            slotIdx     <= '0;
            anyValid    <= 1'b0;
            moveCount   <= '0;
            overflowReg <= 1'b0;
        end else begin
            state     <= stateNext;
            startPrev <= start;
            if (launch) begin
                moveCount   <= '0;
                overflowReg <= 1'b0;
            end
            if (capture) begin
                wordReg  <= lmg_fifo_out;
                slotIdx  <= '0;
                anyValid <= 1'b0;
            end
            if (step) begin
                slotIdx  <= slotIdx + 3'd1;
                anyValid <= anyValid | ~curSlot[18];
            end
            if (incCount) begin
                moveCount <= moveCount + 8'd1;
            end
            if (setOverflow) begin
                overflowReg <= 1'b1;
            end
        end
    end

    always_comb begin
        stateNext   = state;
        lmg_reset   = 1'b0;
        lmg_rden    = 1'b0;
        ram_req     = 1'b0;
        ram_wraddr  = '0;
        ram_wdata   = '0;
        launch      = 1'b0;
        capture     = 1'b0;
        step        = 1'b0;
        incCount    = 1'b0;
        setOverflow = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (startEdge) begin
                    launch    = 1'b1;
                    stateNext = LRST;
                end
            end
            LRST: begin
                lmg_reset = 1'b1;
                stateNext = WAIT;
            end
            WAIT: begin
                if (lmg_done) begin
                    stateNext = POP;
                end
            end
            POP: begin
                if (lmg_fifo_empty) begin
                    stateNext = HDR;
                end else begin
                    lmg_rden  = 1'b1;
                    stateNext = LAT;
                end
            end
            LAT: begin
                capture   = 1'b1;
                stateNext = SCAN;
            end
            SCAN: begin
                if (curSlot[18]) begin
                    step = 1'b1;
                end else if (moveCount < maxMoves) begin
                    ram_req    = 1'b1;
                    ram_wraddr = baseAddr + ADDR_WIDTH'(moveCount);
                    ram_wdata  = {14'd0, curSlot[17:0]};
                    if (ram_gnt) begin
                        step     = 1'b1;
                        incCount = 1'b1;
                    end
                end else begin
                    setOverflow = 1'b1;
                    step        = 1'b1;
                end
                // A word with no valid slot marks the end of the move stream.
                if (step && (slotIdx == 3'd7)) begin
                    stateNext = (anyValid || !curSlot[18]) ? POP : HDR;
                end
            end
            HDR: begin
                ram_req    = 1'b1;
                ram_wraddr = hdrAddr;
                ram_wdata  = {overflowReg, 23'd0, moveCount};
                if (ram_gnt) begin
`ifdef LMG_DRAIN_TERMINATOR_EN
                    stateNext = TERM;
`else
                    stateNext = DONE;
`endif
                end
            end
`ifdef LMG_DRAIN_TERMINATOR_EN
            TERM: begin
                ram_req    = 1'b1;
                ram_wraddr = baseAddr + ADDR_WIDTH'(moveCount);
                ram_wdata  = 32'd0;
                if (ram_gnt) begin
                    stateNext = DONE;
                end
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lmg_drain_sequencer.sv
// Directed bench for lmg_drain_sequencer: FIFO and RAM models, vector table plus corner-case sequences.
`timescale 1ns/1ps
module tb_lmg_drain_sequencer;

`ifdef LMG_DRAIN_TERMINATOR_EN
    localparam int TERM_EN = 1;
`else
    localparam int TERM_EN = 0;
`endif
    localparam logic [31:0] POISON = 32'hDEADBEEF;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         busy;
    logic         done;
    logic [7:0]   move_count;
    logic         overflow;
    logic         lmg_reset;
    logic         lmg_done;
    logic         lmg_fifo_empty;
    logic         lmg_rden;
    logic [151:0] lmg_fifo_out = '0;
    logic         ram_req;
    logic         ram_gnt;
    logic         ram_wren;
    logic [14:0]  ram_wraddr;
    logic [31:0]  ram_wdata;

    lmg_drain_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .move_count(move_count), .overflow(overflow), .lmg_reset(lmg_reset),
        .lmg_done(lmg_done), .lmg_fifo_empty(lmg_fifo_empty), .lmg_rden(lmg_rden),
        .lmg_fifo_out(lmg_fifo_out), .ram_req(ram_req), .ram_gnt(ram_gnt),
        .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_wdata(ram_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FIFO model: initial pushes (fifoWr), monitor pops (fifoRd)
    logic [151:0] fifoMem [128];
    int fifoWr = 0;
    int fifoRd = 0;
    assign lmg_fifo_empty = (fifoRd >= fifoWr);

    // RAM / event log model
    logic [31:0] ramMem [512];
    int wrCount [512];
    int totalWrites;
    int lrstCount;
    int rdenCyc;
    int reqCyc;
    int cyc = 0;
    logic ramClear = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ramClear) begin
            for (int i = 0; i < 512; i++) begin
                ramMem[i]  <= POISON;
                wrCount[i] <= 0;
            end
            totalWrites <= 0;
            lrstCount   <= 0;
            rdenCyc     <= -1;
            reqCyc      <= -1;
        end else begin
            if (ram_wren) begin
                ramMem[ram_wraddr[8:0]]  <= ram_wdata;
                wrCount[ram_wraddr[8:0]] <= wrCount[ram_wraddr[8:0]] + 1;
                totalWrites <= totalWrites + 1;
            end
            if (lmg_reset) lrstCount <= lrstCount + 1;
            if (lmg_rden && rdenCyc < 0) rdenCyc <= cyc;
            if (ram_req && reqCyc < 0) reqCyc <= cyc;
        end
        if (lmg_rden) begin
            lmg_fifo_out <= fifoMem[fifoRd % 128];
            fifoRd <= fifoRd + 1;
        end
    end

    typedef struct {
        string        name;
        bit           hasWord;
        logic [151:0] word;
        int           expCount;
        logic [31:0]  expFirst;
    } vec_t;
    vec_t vecs [5];

    logic [151:0] allInv;
    logic [151:0] w1;
    logic [151:0] wTmp;
    int cnt;
    int stable;
    int n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic checkIdle(input string name);
        check(name, {busy, done, lmg_reset, lmg_rden, ram_req, ram_wren, overflow,
                     move_count, ram_wraddr, ram_wdata}, 64'd0);
    endtask

    function automatic logic [151:0] putSlot(input logic [151:0] w, input int i, input logic [17:0] mv);
        logic [151:0] r;
        r = w;
        r[19*i +: 19] = {1'b0, mv};
        return r;
    endfunction

    task automatic push(input logic [151:0] w);
        fifoMem[fifoWr % 128] = w;
        fifoWr++;
    endtask

    task automatic flush();
        fifoWr = fifoRd;
    endtask

    task automatic clearLog();
        ramClear = 1'b1;
        @(posedge clk);
        #1 ramClear = 1'b0;
    endtask

    task automatic launch();
        @(negedge clk);
        lmg_done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("lrstHigh", {lmg_reset, busy}, 2'b11);
        start = 1'b0;
        @(negedge clk);
        check("lrstLow", lmg_reset, 1'b0);
    endtask

    task automatic releaseLmg();
        repeat (2) @(negedge clk);
        lmg_done = 1'b1;
    endtask

    task automatic waitDone(input string name, input int bound);
        int k;
        k = 0;
        while (!done && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(name, done, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        lmg_done = 1'b0;
        ram_gnt = 1'b1;

        allInv = '0;
        for (int i = 0; i < 8; i++) allInv[19*i + 18] = 1'b1;
        w1 = putSlot(putSlot(putSlot(allInv, 0, 18'h00123), 2, 18'h3FFFF), 5, 18'h00001);

        vecs[0] = '{"slots025", 1'b1, w1, 3, 32'h00000123};
        wTmp = '0;
        for (int i = 0; i < 8; i++) wTmp = putSlot(wTmp, i, 18'(16 + i));
        vecs[1] = '{"allValid", 1'b1, wTmp, 8, 32'h00000010};
        vecs[2] = '{"slot7only", 1'b1, putSlot(allInv, 7, 18'h2AAAA), 1, 32'h0002AAAA};
        vecs[3] = '{"emptyFifo", 1'b0, '0, 0, (TERM_EN != 0) ? 32'd0 : POISON};
        vecs[4] = '{"allInvalid", 1'b1, allInv, 0, (TERM_EN != 0) ? 32'd0 : POISON};

        clearLog();
        @(negedge clk);
        checkIdle("resetHeld");
        reset = 1'b0;
        @(negedge clk);
        checkIdle("afterReset");

        // Table-driven single-word runs
        for (int v = 0; v < 5; v++) begin
            clearLog();
            flush();
            if (vecs[v].hasWord) push(vecs[v].word);
            launch();
            releaseLmg();
            waitDone($sformatf("v%0d_done", v), 500);
            cnt = vecs[v].expCount;
            check($sformatf("v%0d_count", v), move_count, cnt);
            check($sformatf("v%0d_busy", v), busy, 1'b0);
            check($sformatf("v%0d_ovf", v), overflow, 1'b0);
            check($sformatf("v%0d_hdr", v), ramMem[16], cnt);
            check($sformatf("v%0d_hdrWrites", v), wrCount[16], 1);
            check($sformatf("v%0d_first", v), ramMem[17], vecs[v].expFirst);
            check($sformatf("v%0d_term", v), ramMem[17 + cnt], (TERM_EN != 0) ? 32'd0 : POISON);
            check($sformatf("v%0d_termWrites", v), wrCount[17 + cnt], TERM_EN);
            check($sformatf("v%0d_total", v), totalWrites, cnt + 1 + TERM_EN);
            $display("vector %0d %s: move_count=%0d header=0x%08h writes=%0d",
                     v, vecs[v].name, move_count, ramMem[16], totalWrites);
        end

        // Valid word, all-invalid word, then an unread word that must stay in the FIFO
        clearLog();
        flush();
        push(w1);
        push(allInv);
        push(putSlot(allInv, 0, 18'h00777));
        launch();
        releaseLmg();
        waitDone("seq1_done", 500);
        check("seq1_w17", ramMem[17], 32'h123);
        check("seq1_w18", ramMem[18], 32'h3FFFF);
        check("seq1_w19", ramMem[19], 32'h1);
        check("seq1_hdr", ramMem[16], 32'h3);
        check("seq1_w20", ramMem[20], (TERM_EN != 0) ? 32'd0 : POISON);
        check("seq1_count", move_count, 8'd3);
        check("seq1_fifoLeft", fifoWr - fifoRd, 1);
        check("seq1_latency", reqCyc - rdenCyc, 2);
        $display("sequence allInvalidStop: move_count=%0d fifo_left=%0d", move_count, fifoWr - fifoRd);

        // Grant withheld on the second write
        clearLog();
        flush();
        push(w1);
        push(allInv);
        launch();
        releaseLmg();
        n = 0;
        while (!(ram_req && ram_wraddr == 15'd18) && n < 100) begin
            @(negedge clk);
            n++;
        end
        ram_gnt = 1'b0;
        stable = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (ram_req && ram_wraddr == 15'd18 && ram_wdata == 32'h3FFFF) stable++;
            if (c == 5) ram_gnt = 1'b1;
        end
        check("stall_stable", stable, 6);
        waitDone("stall_done", 500);
        check("stall_w18Writes", wrCount[18], 1);
        check("stall_w18", ramMem[18], 32'h3FFFF);
        check("stall_w19", ramMem[19], 32'h1);
        check("stall_count", move_count, 8'd3);
        $display("sequence grantStall: stable_cycles=%0d writes_at_18=%0d", stable, wrCount[18]);

        // 33 full words: saturation at 255
        clearLog();
        flush();
        for (int w = 0; w < 33; w++) begin
            wTmp = '0;
            for (int s = 0; s < 8; s++) wTmp = putSlot(wTmp, s, 18'(w * 8 + s + 1));
            push(wTmp);
        end
        launch();
        releaseLmg();
        waitDone("ovf_done", 2000);
        check("ovf_count", move_count, 8'd255);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_hdr", ramMem[16], 32'h800000FF);
        check("ovf_w17", ramMem[17], 32'd1);
        check("ovf_w271", ramMem[271], 32'd255);
        check("ovf_w272", ramMem[272], (TERM_EN != 0) ? 32'd0 : POISON);
        check("ovf_total", totalWrites, 256 + TERM_EN);
        $display("sequence overflow: move_count=%0d header=0x%08h writes=%0d",
                 move_count, ramMem[16], totalWrites);

        // start toggled while busy, lmg_done dropped after WAIT
        clearLog();
        flush();
        push(w1);
        launch();
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            start = ~start;
        end
        lmg_done = 1'b1;
        @(negedge clk);
        lmg_done = 1'b0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        waitDone("tog_done", 500);
        check("tog_lrstPulses", lrstCount, 1);
        check("tog_count", move_count, 8'd3);
        check("tog_w18", ramMem[18], 32'h3FFFF);
        check("tog_hdr", ramMem[16], 32'h3);
        $display("sequence startWhileBusy: lmg_reset_pulses=%0d move_count=%0d", lrstCount, move_count);

        // Reset during SCAN, then a clean run
        clearLog();
        flush();
        wTmp = '0;
        for (int i = 0; i < 8; i++) wTmp = putSlot(wTmp, i, 18'(16 + i));
        push(wTmp);
        launch();
        lmg_done = 1'b1;
        n = 0;
        while (move_count != 8'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_reachedScan", move_count, 8'd3);
        reset = 1'b1;
        #1 checkIdle("rst_async");
        @(negedge clk);
        checkIdle("rst_nextCycle");
        reset = 1'b0;
        flush();
        clearLog();
        push(w1);
        launch();
        releaseLmg();
        waitDone("rst_rerunDone", 500);
        check("rst_rerunCount", move_count, 8'd3);
        check("rst_rerunW17", ramMem[17], 32'h123);
        check("rst_rerunHdr", ramMem[16], 32'h3);
        $display("sequence resetMidRun: rerun move_count=%0d header=0x%08h", move_count, ramMem[16]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lmg_drain_sequencer.md
# lmg_drain_sequencer

Sequencer between the legal-move generator (LMG) and the move-list block RAM. On `start` it:
- pulses the LMG reset and waits for LMG done;
- pops 152-bit FIFO words, unpacks the eight 19-bit move slots and writes each valid move to consecutive RAM words;
- finishes with a count header and `done`.

The RAM write port is shared with the Avalon slave through a request/grant handshake; the slave side owns the arbiter and has priority.

## Interface
Parameters:
- `ADDR_WIDTH`, 15, RAM address width
- `BASE_ADDR`, 17, address of first move word
- `HDR_ADDR`, 16, address of count header word
- `MAX_MOVES`, 255, move-count saturation limit (count register is 8 bits)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high; all state cleared
- `start`  in  1  level; rising edge (IDLE or DONE only) launches a run
- `busy`  out  1  high in every state except IDLE/DONE
- `done`  out  1  high in DONE
- `move_count`  out  8  valid moves written so far
- `overflow`  out  1  sticky; a valid move was discarded at saturation
- `lmg_reset`  out  1  one-cycle LMG reset pulse
- `lmg_done`  in  1  LMG finished generating
- `lmg_fifo_empty`  in  1  LMG FIFO empty
- `lmg_rden`  out  1  one-cycle FIFO pop
- `lmg_fifo_out`  in  152  FIFO word, valid one cycle after `lmg_rden`
- `ram_req`  out  1  write request; address/data held stable while high
- `ram_gnt`  in  1  arbiter grant
- `ram_wren`  out  1  `ram_req & ram_gnt` (combinational)
- `ram_wraddr`  out  ADDR_WIDTH  write address
- `ram_wdata`  out  32  write data

## Operation
- Slot i, where i = 0..7, occupies bits `[19i+18:19i]`.
  - Bit `19i+18` = 1 means the slot is invalid.
  - Bits `[19i+17:19i]` hold the move, zero-extended to 32 bits on write.
- FSM states and transitions:
  - IDLE: on `start` rising edge, go to LRST. Clear `move_count` and `overflow`.
  - LRST: `lmg_reset` = 1 for exactly this cycle, then go to WAIT.
  - WAIT: when `lmg_done` = 1, go to POP.
  - POP: if `lmg_fifo_empty`, go to HDR. Otherwise assert `lmg_rden` and go to LAT.
  - LAT: capture `lmg_fifo_out` into the word register. Set slot index to 0 and go to SCAN.
  - SCAN: examine the current slot.
    - Invalid slot: advance in one cycle, no write.
    - Valid slot and `move_count` < MAX_MOVES:
      - assert `ram_req` with `ram_wraddr` = BASE_ADDR + `move_count`;
      - hold until the grant cycle;
      - on grant, increment `move_count` and advance the slot.
    - Valid slot at saturation: set `overflow`, no write, advance in one cycle.
    - After slot 7: if all 8 slots were invalid, go to HDR; otherwise go to POP.
  - HDR: request a write of `{overflow, 23'b0, move_count}` to HDR_ADDR. On grant, go to TERM.
  - TERM: request a write of 0 to BASE_ADDR + `move_count`. On grant, go to DONE.
  - DONE: `done` = 1. A `start` rising edge restarts the run at LRST.
- A `start` edge while `busy` is ignored.
- Any deassertion of `lmg_done` after WAIT is ignored.
- Address arithmetic is ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH, and is never checked against HDR_ADDR.

## Timing
- Reset values: state IDLE; `busy`, `done`, `lmg_reset`, `lmg_rden`, `ram_req`, `ram_wren`, `overflow` = 0; `move_count` = 0; `ram_wraddr`/`ram_wdata` = 0.
- Start edge sampled at cycle n; `lmg_reset` is high at cycle n+1.
- `lmg_rden` at cycle k; data captured at k+1; slot 0 evaluated at k+2.
- Per word with continuous grant: 8 SCAN cycles, plus POP and LAT.
- Each write commits on the rising edge ending the cycle where `ram_req & ram_gnt` is high. `ram_req` drops or changes on the following cycle.
- Grant withheld: stall indefinitely with outputs held. No timeout.
- Reset mid-run: immediately returns to the reset values above. Partially written RAM contents are left in place.
- All-invalid final word plus an empty FIFO: HDR is entered from SCAN, with no extra pop.

## Configuration
- `LMG_DRAIN_TERMINATOR_EN` defined:
  - TERM state present;
  - a zero sentinel word follows the last move.
- Undefined:
  - HDR goes directly to DONE;
  - no sentinel is written;
  - the run is one grant cycle shorter.

## Test plan
- One FIFO word, slots 0,2,5 valid (moves 0x00123, 0x3FFFF, 0x00001), then an all-invalid word. Continuous grant.
  - Writes: [17]=0x123, [18]=0x3FFFF, [19]=0x1, [16]=0x00000003, [20]=0.
  - `done` rises; `move_count` = 3.
- Same stimulus with `ram_gnt` low for 5 cycles on the second write.
  - `ram_wraddr` = 18 and `ram_wdata` = 0x3FFFF stay stable for 6 cycles.
  - Exactly one write at 18.
- FIFO empty at first POP.
  - Header 0 written at 16; sentinel 0 at 17; `done` = 1.
- 33 full words (264 valid moves), then empty.
  - 255 writes (addresses 17..271).
  - `overflow` = 1; header = 0x800000FF.
- `reset` asserted during SCAN.
  - Next cycle: all outputs at reset values.
  - A new start runs cleanly from `move_count` = 0.
- `start` toggled while `busy`.
  - Ignored: no second `lmg_reset` pulse, run unaffected.
